// File: rtl/ps2_rx_frame_if.sv
// rtl/ps2_rx_frame_if.sv - PS/2 receiver pin and result bundle
interface ps2_rx_frame_if;
  logic       key_clk;
  logic       key_din;
  logic [7:0] scancode;
  logic       scancode_stb;
  logic       err_stb;
  logic [1:0] err_code;
  logic       busy;

  modport master (
    output key_clk, key_din,
    input  scancode, scancode_stb, err_stb, err_code, busy
  );

  modport slave (
    input  key_clk, key_din,
    output scancode, scancode_stb, err_stb, err_code, busy
  );
endinterface

// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - PS/2 pin synchroniser, clock glitch filter and 11-bit frame receiver
module ps2_rx_frame #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic            clk25,
  input  logic            reset,
  ps2_rx_frame_if.slave   bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic          clk_s1, clk_s2, din_s1, din_s2;
  logic          filt_clk, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall_det;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic [7:0]    scancode_q;
  logic          scancode_stb_q, err_stb_q;
  logic [1:0]    err_code_q;

  always_ff @(posedge clk25) begin
    if (reset) begin
      clk_s1    <= 1'b1;
      clk_s2    <= 1'b1;
      din_s1    <= 1'b1;
      din_s2    <= 1'b1;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_s1    <= bus.key_clk;
      clk_s2    <= clk_s1;
      din_s1    <= bus.key_din;
      din_s2    <= din_s1;
      filt_prev <= filt_clk;
      // The filtered clock only follows a level that has persisted FILTER_LEN cycles
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt + FW'(1) == FW'(FILTER_LEN)) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall_det = filt_prev & ~filt_clk;

  always_ff @(posedge clk25) begin
    if (reset) begin
      state          <= S_IDLE;
      bit_cnt        <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      to_cnt         <= '0;
      scancode_q     <= '0;
      scancode_stb_q <= 1'b0;
      err_stb_q      <= 1'b0;
      err_code_q     <= 2'd0;
    end else begin
      scancode_stb_q <= 1'b0;
      err_stb_q      <= 1'b0;
      if (fall_det) begin
        to_cnt <= '0;
        case (state)
          S_IDLE: begin
            if (!din_s2) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end
          end
          S_DATA: begin
            shreg   <= {din_s2, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= S_PARITY;
          end
          S_PARITY: begin
            par_bit <= din_s2;
            state   <= S_STOP;
          end
          default: begin
            state <= S_IDLE;
            if (!din_s2) begin
              err_stb_q  <= 1'b1;
              err_code_q <= 2'd2;
            end else if (((^shreg) ^ par_bit) == 1'b0) begin
              err_stb_q  <= 1'b1;
              err_code_q <= 2'd1;
            end else begin
              scancode_q     <= shreg;
              scancode_stb_q <= 1'b1;
            end
          end
        endcase
      end else if (state != S_IDLE) begin
        // Fires on the cycle the count would reach TIMEOUT_CYCLES; a coincident edge wins above
        if (to_cnt + TW'(1) == TW'(TIMEOUT_CYCLES)) begin
          state      <= S_IDLE;
          to_cnt     <= '0;
          err_stb_q  <= 1'b1;
          err_code_q <= 2'd3;
        end else if (to_cnt != '1) begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

  assign bus.scancode     = scancode_q;
  assign bus.scancode_stb = scancode_stb_q;
  assign bus.err_stb      = err_stb_q;
  assign bus.err_code     = err_code_q;
  assign bus.busy         = (state != S_IDLE);
endmodule

// File: tb/tb_ps2_rx_frame.sv
// tb/tb_ps2_rx_frame.sv - self-checking bench for ps2_rx_frame against a frame-level model
module tb_ps2_rx_frame;
  localparam int FL = 8;
  localparam int TO = 200;

  logic clk25 = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;

  ps2_rx_frame_if bus ();

  ps2_rx_frame #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk25 (clk25),
    .reset (reset),
    .bus   (bus)
  );

  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_fail   = 0;
  int n_sc     = 0;
  int n_err    = 0;
  int err_cyc  = 0;

  int   cyc = 0;
  bit   cq[$];
  bit   dq[$];
  bit   m_filt, m_prev;
  int   run, gap, last_fall_cyc;
  logic fb[$];
  logic [7:0] exp_sc;
  logic       exp_sc_stb, exp_err_stb, exp_busy;
  logic [1:0] exp_code;

  // Model: pins delayed two samples, level accepted after FL differing samples, then a bit list per frame
  always @(posedge clk25) begin
    bit s, d, fall, nf;
    logic [7:0] data;
    cyc++;
    if (reset) begin
      cq.delete(); cq.push_back(1'b1); cq.push_back(1'b1);
      dq.delete(); dq.push_back(1'b1); dq.push_back(1'b1);
      m_filt = 1'b1; m_prev = 1'b1; run = 0; gap = 0; fb.delete();
      exp_sc = 8'h00; exp_sc_stb = 1'b0; exp_err_stb = 1'b0; exp_code = 2'd0; exp_busy = 1'b0;
    end else begin
      cq.push_back(bus.key_clk);
      dq.push_back(bus.key_din);
      if (cq.size() > 4) void'(cq.pop_front());
      if (dq.size() > 4) void'(dq.pop_front());
      s = cq[cq.size()-3];
      d = dq[dq.size()-3];
      fall = m_prev && !m_filt;
      nf = m_filt;
      if (s != m_filt) begin
        run++;
        if (run == FL) begin nf = s; run = 0; end
      end else run = 0;
      m_prev = m_filt;
      m_filt = nf;
      exp_sc_stb = 1'b0;
      exp_err_stb = 1'b0;
      if (fall) begin
        gap = 0;
        last_fall_cyc = cyc - 1;
        if (fb.size() > 0 || d == 1'b0) fb.push_back(d);
        if (fb.size() == 11) begin
          for (int i = 0; i < 8; i++) data[i] = fb[i+1];
          if (fb[10] == 1'b0) begin exp_err_stb = 1'b1; exp_code = 2'd2; end
          else if (((^data) ^ fb[9]) == 1'b0) begin exp_err_stb = 1'b1; exp_code = 2'd1; end
          else begin exp_sc = data; exp_sc_stb = 1'b1; end
          fb.delete();
        end
      end else if (fb.size() > 0) begin
        gap++;
        if (gap == TO) begin
          exp_err_stb = 1'b1; exp_code = 2'd3; fb.delete(); gap = 0;
        end
      end
      exp_busy = (fb.size() > 0);
    end
  end

  always @(negedge clk25) begin
    if (chk_en) begin
      n_checks++;
      if ({bus.scancode, bus.scancode_stb, bus.err_stb, bus.err_code, bus.busy} !==
          {exp_sc, exp_sc_stb, exp_err_stb, exp_code, exp_busy}) begin
        n_fail++;
        $display("FAIL cycle_compare cyc=%0d got sc=%h stb=%b err=%b code=%0d busy=%b expected sc=%h stb=%b err=%b code=%0d busy=%b",
                 cyc, bus.scancode, bus.scancode_stb, bus.err_stb, bus.err_code, bus.busy,
                 exp_sc, exp_sc_stb, exp_err_stb, exp_code, exp_busy);
      end
      if (bus.scancode_stb === 1'b1) n_sc++;
      if (bus.err_stb === 1'b1) begin n_err++; err_cyc = cyc; end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk25);
  endtask

  task automatic glitch(input int len);
    bus.key_clk = 1'b0;
    cycles(len);
    bus.key_clk = 1'b1;
    cycles(FL + 6);
  endtask

  task automatic send_bit(input logic b, input int half);
    bus.key_din = b;
    cycles(5);
    bus.key_clk = 1'b0;
    cycles(half);
    bus.key_clk = 1'b1;
    cycles(half - 5);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par, input logic stop);
    return {stop, (~^d) ^ bad_par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int first, input int last, input int half, input int glitch_after);
    for (int i = first; i <= last; i++) begin
      send_bit(f[i], half);
      if (i == glitch_after) glitch(3);
    end
    bus.key_din = 1'b1;
  endtask

  task automatic good(input logic [7:0] d);
    send_bits(mk_frame(d, 1'b0, 1'b1), 0, 10, 25, -1);
    cycles(10);
  endtask

  int sc0, er0;

  initial begin
    logic [7:0] rd;
    logic       bp, st;
    int         half, ga, last;
    bus.key_clk = 1'b1;
    bus.key_din = 1'b1;
    reset = 1'b1;
    cycles(2);
    chk_en = 1'b1;
    cycles(2);
    check("reset_scancode", bus.scancode, 8'h00);
    check("reset_err_code", bus.err_code, 0);
    check("reset_busy", bus.busy, 0);
    reset = 1'b0;
    cycles(10);

    sc0 = n_sc; er0 = n_err;
    good(8'h1C);
    check("t1_stb_count", n_sc - sc0, 1);
    check("t1_scancode", bus.scancode, 8'h1C);
    check("t1_model_sc", exp_sc, 8'h1C);
    check("t1_no_err", n_err - er0, 0);
    check("t1_busy", bus.busy, 0);

    sc0 = n_sc; er0 = n_err;
    send_bits(mk_frame(8'hF0, 1'b1, 1'b1), 0, 10, 25, -1);
    cycles(10);
    check("t2_err_count", n_err - er0, 1);
    check("t2_err_code", bus.err_code, 1);
    check("t2_no_stb", n_sc - sc0, 0);
    check("t2_sc_kept", bus.scancode, 8'h1C);
    good(8'h5A);
    check("t2_sc_5a", bus.scancode, 8'h5A);
    check("t2_code_kept", bus.err_code, 1);

    send_bits(mk_frame(8'h12, 1'b0, 1'b0), 0, 10, 25, -1);
    cycles(10);
    check("t3_stop_err", bus.err_code, 2);
    good(8'h5A);
    send_bits(mk_frame(8'h12, 1'b1, 1'b0), 0, 10, 25, -1);
    cycles(10);
    check("t3_stop_over_par", bus.err_code, 2);

    er0 = n_err;
    send_bits(mk_frame(8'h29, 1'b0, 1'b1), 0, 4, 25, -1);
    cycles(TO + 20);
    check("t4_err_count", n_err - er0, 1);
    check("t4_err_code", bus.err_code, 3);
    check("t4_busy", bus.busy, 0);
    check("t4_latency", err_cyc - last_fall_cyc, TO + 1);
    good(8'h29);
    check("t4_sc_29", bus.scancode, 8'h29);

    sc0 = n_sc; er0 = n_err;
    glitch(3);
    check("t5_idle_glitch_busy", bus.busy, 0);
    send_bits(mk_frame(8'h33, 1'b0, 1'b1), 0, 10, 25, 4);
    cycles(10);
    check("t5_sc_33", bus.scancode, 8'h33);
    check("t5_stb_count", n_sc - sc0, 1);
    check("t5_no_err", n_err - er0, 0);
    bus.key_din = 1'b0;
    glitch(FL);
    check("t5_accept_pulse_busy", bus.busy, 1);
    bus.key_din = 1'b1;
    cycles(TO + 20);
    check("t5_pulse_timeout", bus.err_code, 3);

    send_bits(mk_frame(8'h66, 1'b0, 1'b1), 0, 5, 25, -1);
    reset = 1'b1;
    cycles(2);
    check("t6_rst_sc", bus.scancode, 0);
    check("t6_rst_code", bus.err_code, 0);
    check("t6_rst_busy", bus.busy, 0);
    reset = 1'b0;
    send_bits(mk_frame(8'h66, 1'b0, 1'b1), 6, 10, 25, -1);
    cycles(TO + 20);
    good(8'h66);
    check("t6_sc_66", bus.scancode, 8'h66);

    for (int n = 0; n < 20; n++) begin
      rd   = 8'($urandom);
      bp   = ($urandom_range(0, 3) == 0);
      st   = ($urandom_range(0, 7) != 0);
      half = $urandom_range(12, 30);
      ga   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
      last = ($urandom_range(0, 5) == 0) ? $urandom_range(1, 9) : 10;
      send_bits(mk_frame(rd, bp, st), 0, last, half, ga);
      if (last != 10) cycles(TO + 20);
      else cycles($urandom_range(0, 20));
    end
    cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
